// File: rtl/multi_roi_color_detector.sv
// -----------------------------------------------------------------------------
// multi_roi_color_detector
//
// Counts red / green / blue pixels inside up to four rectangular regions of
// interest (ROIs) of a pixel stream. At each frame boundary the counts of the
// frame that just ended are frozen. One ROI per cycle is then decided: the
// dominant colour, whether it passes the confidence threshold, and its count.
// All ROI results are published together with a one-cycle result_ready pulse.
//
// Ports
//   clk                       rising-edge clock
//   reset                     asynchronous, active-low
//   pixel_valid               pixel fields below are valid this cycle
//   frame_start               one-cycle pulse marking the first cycle of a frame
//   x_coord, y_coord          10-bit pixel coordinates
//   pixel_r/g/b               8-bit colour components
//   cfg_we, cfg_idx           write shadow ROI bounds of ROI cfg_idx
//   cfg_x/y_start/end         bounds to write (start inclusive, end exclusive)
//   roi_color                 2 bits per ROI: 00 none, 01 red, 10 green, 11 blue
//   roi_valid                 1 bit per ROI: winner reached MIN_CONFIDENCE
//   roi_confidence            CNT_W bits per ROI: winning count
//   result_ready              one-cycle pulse when the outputs above update
//   overrun                   sticky: a frame started while deciding
//   busy                      high while ROIs are being decided
// -----------------------------------------------------------------------------
module multi_roi_color_detector #(
  parameter int         NUM_ROI        = 2,
  parameter int         CNT_W          = 16,
  parameter int         MIN_CONFIDENCE = 100,
  parameter logic [7:0] RED_R_MIN      = 8'd180,
  parameter logic [7:0] RED_G_MAX      = 8'd100,
  parameter logic [7:0] RED_B_MAX      = 8'd100,
  parameter logic [7:0] GREEN_R_MAX    = 8'd100,
  parameter logic [7:0] GREEN_G_MIN    = 8'd180,
  parameter logic [7:0] GREEN_B_MAX    = 8'd100,
  parameter logic [7:0] BLUE_R_MAX     = 8'd100,
  parameter logic [7:0] BLUE_G_MAX     = 8'd100,
  parameter logic [7:0] BLUE_B_MIN     = 8'd180,
  parameter logic [9:0] DEF_X_START    = 10'd100,
  parameter logic [9:0] DEF_X_END      = 10'd220,
  parameter logic [9:0] DEF_Y_START    = 10'd60,
  parameter logic [9:0] DEF_Y_END      = 10'd180
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     pixel_valid,
  input  logic                     frame_start,
  input  logic [9:0]               x_coord,
  input  logic [9:0]               y_coord,
  input  logic [7:0]               pixel_r,
  input  logic [7:0]               pixel_g,
  input  logic [7:0]               pixel_b,
  input  logic                     cfg_we,
  input  logic [1:0]               cfg_idx,
  input  logic [9:0]               cfg_x_start,
  input  logic [9:0]               cfg_x_end,
  input  logic [9:0]               cfg_y_start,
  input  logic [9:0]               cfg_y_end,
  output logic [2*NUM_ROI-1:0]     roi_color,
  output logic [NUM_ROI-1:0]       roi_valid,
  output logic [CNT_W*NUM_ROI-1:0] roi_confidence,
  output logic                     result_ready,
  output logic                     overrun,
  output logic                     busy
);

  typedef enum logic [1:0] {IDLE, ACCUM, DECIDE} state_t;

  typedef struct packed {
    logic [9:0] xs;
    logic [9:0] xe;
    logic [9:0] ys;
    logic [9:0] ye;
  } bounds_t;

  localparam logic [1:0]  LAST_IDX = 2'(NUM_ROI - 1);
  localparam logic [31:0] MIN_C    = 32'(MIN_CONFIDENCE);

  state_t           state_q, state_d;
  logic [1:0]       idx_q, idx_d;
  bounds_t          act_q [NUM_ROI];
  bounds_t          act_d [NUM_ROI];
  bounds_t          shd_q [NUM_ROI];
  bounds_t          shd_d [NUM_ROI];
  // counter index 0 = red, 1 = green, 2 = blue
  logic [CNT_W-1:0] cnt_q  [NUM_ROI][3];
  logic [CNT_W-1:0] cnt_d  [NUM_ROI][3];
  logic [CNT_W-1:0] hold_q [NUM_ROI][3];
  logic [CNT_W-1:0] hold_d [NUM_ROI][3];
  // per-ROI decisions collected during DECIDE, published all at once
  logic [1:0]       stg_color_q [NUM_ROI];
  logic [1:0]       stg_color_d [NUM_ROI];
  logic             stg_valid_q [NUM_ROI];
  logic             stg_valid_d [NUM_ROI];
  logic [CNT_W-1:0] stg_conf_q  [NUM_ROI];
  logic [CNT_W-1:0] stg_conf_d  [NUM_ROI];

  logic [2*NUM_ROI-1:0]     color_q, color_d;
  logic [NUM_ROI-1:0]       valid_q, valid_d;
  logic [CNT_W*NUM_ROI-1:0] conf_q, conf_d;
  logic                     ready_q, ready_d;
  logic                     overrun_q, overrun_d;

  function automatic bounds_t reset_bounds(int i);
    if (i == 0) return {DEF_X_START, DEF_X_END, DEF_Y_START, DEF_Y_END};
    return '0;
  endfunction

  // ---------------------------------------------------------------------------
  // Pixel classification; red wins over green wins over blue on overlap.
  // ---------------------------------------------------------------------------
  logic       is_red, is_green, is_blue;
  logic [1:0] pix_cls;

  always_comb begin
    is_red   = (pixel_r >= RED_R_MIN)   && (pixel_g <= RED_G_MAX)   && (pixel_b <= RED_B_MAX);
    is_green = (pixel_r <= GREEN_R_MAX) && (pixel_g >= GREEN_G_MIN) && (pixel_b <= GREEN_B_MAX);
    is_blue  = (pixel_r <= BLUE_R_MAX)  && (pixel_g <= BLUE_G_MAX)  && (pixel_b >= BLUE_B_MIN);
    pix_cls  = 2'b00;
    if (is_red)        pix_cls = 2'b01;
    else if (is_green) pix_cls = 2'b10;
    else if (is_blue)  pix_cls = 2'b11;
  end

  // ---------------------------------------------------------------------------
  // Decision for the ROI selected by idx_q, taken from the frozen counts.
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] sel_r, sel_g, sel_b, win_cnt;
  logic [1:0]       win_code;
  logic             win_ok;

  always_comb begin
    sel_r = hold_q[0][0];
    sel_g = hold_q[0][1];
    sel_b = hold_q[0][2];
    for (int i = 1; i < NUM_ROI; i++) begin
      if (idx_q == 2'(i)) begin
        sel_r = hold_q[i][0];
        sel_g = hold_q[i][1];
        sel_b = hold_q[i][2];
      end
    end
    if (sel_r >= sel_g && sel_r >= sel_b) begin
      win_code = 2'b01;
      win_cnt  = sel_r;
    end else if (sel_g >= sel_b) begin
      win_code = 2'b10;
      win_cnt  = sel_g;
    end else begin
      win_code = 2'b11;
      win_cnt  = sel_b;
    end
    win_ok = !(32'(win_cnt) < MIN_C);
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  logic count_en;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    act_d       = act_q;
    shd_d       = shd_q;
    cnt_d       = cnt_q;
    hold_d      = hold_q;
    stg_color_d = stg_color_q;
    stg_valid_d = stg_valid_q;
    stg_conf_d  = stg_conf_q;
    color_d     = color_q;
    valid_d     = valid_q;
    conf_d      = conf_q;
    ready_d     = 1'b0;
    overrun_d   = overrun_q;

    case (state_q)
      IDLE: begin
        // The first frame has nothing before it to decide on.
        if (frame_start) state_d = ACCUM;
      end
      ACCUM: begin
        if (frame_start) begin
          hold_d  = cnt_q;
          idx_d   = 2'd0;
          state_d = DECIDE;
        end
      end
      DECIDE: begin
        // A frame boundary here still restarts counting (below) but the
        // decision in flight keeps working on the snapshot it already has.
        if (frame_start) overrun_d = 1'b1;
        for (int i = 0; i < NUM_ROI; i++) begin
          if (idx_q == 2'(i)) begin
            stg_color_d[i] = win_ok ? win_code : 2'b00;
            stg_valid_d[i] = win_ok;
            stg_conf_d[i]  = win_cnt;
          end
        end
        if (idx_q == LAST_IDX) begin
          for (int i = 0; i < NUM_ROI; i++) begin
            color_d[2*i +: 2]         = stg_color_d[i];
            valid_d[i]                = stg_valid_d[i];
            conf_d[CNT_W*i +: CNT_W]  = stg_conf_d[i];
          end
          ready_d = 1'b1;
          state_d = ACCUM;
        end else begin
          idx_d = idx_q + 2'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Frame boundary: bounds take effect from the shadow as it stood before
    // any configuration write in this same cycle, and counting restarts.
    if (frame_start) begin
      act_d = shd_q;
      for (int i = 0; i < NUM_ROI; i++)
        for (int k = 0; k < 3; k++)
          cnt_d[i][k] = '0;
    end

    // The frame_start pixel belongs to the new frame, so counting is
    // enabled on it even when leaving IDLE.
    count_en = pixel_valid && ((state_q != IDLE) || frame_start);
    for (int i = 0; i < NUM_ROI; i++) begin
      if (count_en &&
          x_coord >= act_d[i].xs && x_coord < act_d[i].xe &&
          y_coord >= act_d[i].ys && y_coord < act_d[i].ye) begin
        for (int k = 0; k < 3; k++) begin
          if (pix_cls == 2'(k + 1) && cnt_d[i][k] != '1)
            cnt_d[i][k] = cnt_d[i][k] + CNT_W'(1);
        end
      end
    end

    // Indices beyond the implemented ROIs match no entry and are dropped.
    for (int i = 0; i < NUM_ROI; i++) begin
      if (cfg_we && cfg_idx == 2'(i))
        shd_d[i] = {cfg_x_start, cfg_x_end, cfg_y_start, cfg_y_end};
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      idx_q     <= 2'd0;
      color_q   <= '0;
      valid_q   <= '0;
      conf_q    <= '0;
      ready_q   <= 1'b0;
      overrun_q <= 1'b0;
      for (int i = 0; i < NUM_ROI; i++) begin
        act_q[i]       <= reset_bounds(i);
        shd_q[i]       <= reset_bounds(i);
        stg_color_q[i] <= 2'b00;
        stg_valid_q[i] <= 1'b0;
        stg_conf_q[i]  <= '0;
        for (int k = 0; k < 3; k++) begin
          cnt_q[i][k]  <= '0;
          hold_q[i][k] <= '0;
        end
      end
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      act_q       <= act_d;
      shd_q       <= shd_d;
      cnt_q       <= cnt_d;
      hold_q      <= hold_d;
      stg_color_q <= stg_color_d;
      stg_valid_q <= stg_valid_d;
      stg_conf_q  <= stg_conf_d;
      color_q     <= color_d;
      valid_q     <= valid_d;
      conf_q      <= conf_d;
      ready_q     <= ready_d;
      overrun_q   <= overrun_d;
    end
  end

  assign roi_color      = color_q;
  assign roi_valid      = valid_q;
  assign roi_confidence = conf_q;
  assign result_ready   = ready_q;
  assign overrun        = overrun_q;
  assign busy           = (state_q == DECIDE);

endmodule

// File: tb/tb_multi_roi_color_detector.sv
// -----------------------------------------------------------------------------
// Bench for multi_roi_color_detector. Two instances share one stimulus: one
// with default parameters and one with 8-bit counters (for saturation). A
// frame-level reference model tracks bounds and per-colour pixel counts and
// queues the expected result of every decision; a monitor pops and compares
// whenever an instance raises result_ready.
// -----------------------------------------------------------------------------
module tb_multi_roi_color_detector;

  localparam int NR = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       pixel_valid = 1'b0, frame_start = 1'b0;
  logic [9:0] x_coord = '0, y_coord = '0;
  logic [7:0] pixel_r = '0, pixel_g = '0, pixel_b = '0;
  logic       cfg_we = 1'b0;
  logic [1:0] cfg_idx = '0;
  logic [9:0] cfg_xs = '0, cfg_xe = '0, cfg_ys = '0, cfg_ye = '0;

  logic [2*NR-1:0]  color_a, color_b;
  logic [NR-1:0]    valid_a, valid_b;
  logic [16*NR-1:0] conf_a;
  logic [8*NR-1:0]  conf_b;
  logic             ready_a, ready_b, ovr_a, ovr_b, busy_a, busy_b;

  multi_roi_color_detector #(.NUM_ROI(NR)) dut_a (
    .clk(clk), .reset(rst_n), .pixel_valid(pixel_valid), .frame_start(frame_start),
    .x_coord(x_coord), .y_coord(y_coord), .pixel_r(pixel_r), .pixel_g(pixel_g), .pixel_b(pixel_b),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_x_start(cfg_xs), .cfg_x_end(cfg_xe),
    .cfg_y_start(cfg_ys), .cfg_y_end(cfg_ye),
    .roi_color(color_a), .roi_valid(valid_a), .roi_confidence(conf_a),
    .result_ready(ready_a), .overrun(ovr_a), .busy(busy_a));

  multi_roi_color_detector #(.NUM_ROI(NR), .CNT_W(8)) dut_b (
    .clk(clk), .reset(rst_n), .pixel_valid(pixel_valid), .frame_start(frame_start),
    .x_coord(x_coord), .y_coord(y_coord), .pixel_r(pixel_r), .pixel_g(pixel_g), .pixel_b(pixel_b),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_x_start(cfg_xs), .cfg_x_end(cfg_xe),
    .cfg_y_start(cfg_ys), .cfg_y_end(cfg_ye),
    .roi_color(color_b), .roi_valid(valid_b), .roi_confidence(conf_b),
    .result_ready(ready_b), .overrun(ovr_b), .busy(busy_b));

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(string name, logic [63:0] got, logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
  endtask

  // ---------------------------------------------------------------------------
  // Reference model (frame level)
  // ---------------------------------------------------------------------------
  typedef struct packed {
    logic [2*NR-1:0]  color;
    logic [NR-1:0]    valid;
    logic [16*NR-1:0] conf;
  } res_t;

  int   m_mode;          // 0 idle, 1 accumulating, 2 deciding
  int   m_left;          // decide cycles remaining
  int   m_cnt [NR][3];   // exact pixel counts of the current frame
  int   m_act [NR][4];
  int   m_shd [NR][4];
  bit   m_ovr, m_ready;
  res_t m_pa, m_pb;
  res_t qa[$], qb[$];

  function automatic int classify(int r, int g, int b);
    if (r >= 180 && g <= 100 && b <= 100) return 1;
    if (r <= 100 && g >= 180 && b <= 100) return 2;
    if (r <= 100 && g <= 100 && b >= 180) return 3;
    return 0;
  endfunction

  // Result of the counts so far, as a counter of width w would report it.
  function automatic res_t make_res(int w);
    res_t r;
    int lim, c[3], code, win;
    r = '0;
    lim = (1 << w) - 1;
    for (int i = 0; i < NR; i++) begin
      for (int k = 0; k < 3; k++) c[k] = (m_cnt[i][k] > lim) ? lim : m_cnt[i][k];
      if (c[0] >= c[1] && c[0] >= c[2]) begin code = 1; win = c[0]; end
      else if (c[1] >= c[2])            begin code = 2; win = c[1]; end
      else                              begin code = 3; win = c[2]; end
      r.conf[16*i +: 16] = 16'(win);
      if (win >= 100) begin
        r.color[2*i +: 2] = 2'(code);
        r.valid[i] = 1'b1;
      end
    end
    return r;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_left = 0; m_ovr = 0; m_ready = 0;
    for (int i = 0; i < NR; i++) begin
      for (int k = 0; k < 3; k++) m_cnt[i][k] = 0;
      for (int k = 0; k < 4; k++) begin m_act[i][k] = 0; m_shd[i][k] = 0; end
    end
    m_act[0][0] = 100; m_act[0][1] = 220; m_act[0][2] = 60; m_act[0][3] = 180;
    m_shd[0] = m_act[0];
    qa.delete(); qb.delete();
  endtask

  task automatic model_step();
    int  prev_mode, cls;
    bit  fs;
    fs = frame_start;
    prev_mode = m_mode;
    m_ready = 0;
    if (m_mode == 2) begin
      if (fs) m_ovr = 1;
      m_left--;
      if (m_left == 0) begin
        m_mode = 1; m_ready = 1;
        qa.push_back(m_pa); qb.push_back(m_pb);
      end
    end else if (fs) begin
      if (m_mode == 1) begin
        m_pa = make_res(16); m_pb = make_res(8);
        m_mode = 2; m_left = NR;
      end else m_mode = 1;
    end
    if (fs) begin
      m_act = m_shd;
      for (int i = 0; i < NR; i++) for (int k = 0; k < 3; k++) m_cnt[i][k] = 0;
    end
    if (pixel_valid && (prev_mode != 0 || fs)) begin
      cls = classify(int'(pixel_r), int'(pixel_g), int'(pixel_b));
      for (int i = 0; i < NR; i++)
        if (cls != 0 && int'(x_coord) >= m_act[i][0] && int'(x_coord) < m_act[i][1] &&
            int'(y_coord) >= m_act[i][2] && int'(y_coord) < m_act[i][3])
          m_cnt[i][cls-1]++;
    end
    if (cfg_we && int'(cfg_idx) < NR) begin
      m_shd[cfg_idx][0] = int'(cfg_xs); m_shd[cfg_idx][1] = int'(cfg_xe);
      m_shd[cfg_idx][2] = int'(cfg_ys); m_shd[cfg_idx][3] = int'(cfg_ye);
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else        model_step();
    end
  end

  // ---------------------------------------------------------------------------
  // Monitor: sampled on the falling edge
  // ---------------------------------------------------------------------------
  task automatic cmp_res(string tag, res_t e, logic [3:0] col, logic [1:0] val, logic [31:0] conf);
    $display("%s result: color=%b valid=%b conf=%08h (expected %b %b %08h)",
             tag, col, val, conf, e.color, e.valid, e.conf);
    check({tag, "_color"}, 64'(col), 64'(e.color));
    check({tag, "_valid"}, 64'(val), 64'(e.valid));
    check({tag, "_conf"},  64'(conf), 64'(e.conf));
  endtask

  initial begin
    res_t e;
    forever begin
      @(negedge clk);
      check("busy_a", 64'(busy_a), 64'(m_mode == 2));
      check("busy_b", 64'(busy_b), 64'(m_mode == 2));
      check("overrun_a", 64'(ovr_a), 64'(m_ovr));
      check("overrun_b", 64'(ovr_b), 64'(m_ovr));
      check("ready_a", 64'(ready_a), 64'(m_ready));
      check("ready_b", 64'(ready_b), 64'(m_ready));
      if (ready_a) begin
        if (qa.size() == 0) check("ready_a_unexpected", 64'(1), 64'(0));
        else begin
          e = qa.pop_front();
          cmp_res("dut_a", e, color_a, valid_a, conf_a);
        end
      end
      if (ready_b) begin
        if (qb.size() == 0) check("ready_b_unexpected", 64'(1), 64'(0));
        else begin
          e = qb.pop_front();
          cmp_res("dut_b", e, color_b, valid_b, {8'h00, conf_b[15:8], 8'h00, conf_b[7:0]});
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pix(int x, int y, int r, int g, int b, int n);
    pixel_valid = 1'b1;
    x_coord = 10'(x); y_coord = 10'(y);
    pixel_r = 8'(r); pixel_g = 8'(g); pixel_b = 8'(b);
    repeat (n) tick();
    pixel_valid = 1'b0;
  endtask

  task automatic cfg(int idx, int xs, int xe, int ys, int ye);
    cfg_we = 1'b1; cfg_idx = 2'(idx);
    cfg_xs = 10'(xs); cfg_xe = 10'(xe); cfg_ys = 10'(ys); cfg_ye = 10'(ye);
    tick();
    cfg_we = 1'b0;
  endtask

  // Frame boundary, then advance to the cycle where the result is due.
  task automatic fs_wait();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    int nready, nb, gap, sel;
    // reset state
    repeat (3) tick();
    check("rst_color", 64'(color_a), 64'(0));
    check("rst_valid", 64'(valid_a), 64'(0));
    check("rst_conf",  64'(conf_a),  64'(0));
    check("rst_ready", 64'(ready_a), 64'(0));
    check("rst_busy",  64'(busy_a),  64'(0));
    rst_n = 1'b1;
    tick();

    // 200 red pixels -> red, valid, confidence 200, three cycles after frame_start
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    pix(150, 100, 255, 0, 0, 200);
    fs_wait();
    check("red_ready", 64'(ready_a), 64'(1));
    check("red_color", 64'(color_a[1:0]), 64'(1));
    check("red_valid", 64'(valid_a[0]), 64'(1));
    check("red_conf",  64'(conf_a[15:0]), 64'(200));

    // 50 blue pixels: below threshold
    pix(150, 100, 0, 0, 255, 50);
    fs_wait();
    check("blue_low_color", 64'(color_a[1:0]), 64'(0));
    check("blue_low_valid", 64'(valid_a[0]), 64'(0));
    check("blue_low_conf",  64'(conf_a[15:0]), 64'(50));

    // ROI 1 programmed mid-frame takes effect only from the next frame
    cfg(1, 0, 50, 0, 50);
    pix(10, 10, 0, 255, 0, 120);
    fs_wait();
    check("roi1_first_color", 64'(color_a[3:2]), 64'(0));
    check("roi1_first_conf",  64'(conf_a[31:16]), 64'(0));
    pix(10, 10, 0, 255, 0, 120);
    fs_wait();
    check("roi1_second_color", 64'(color_a[3:2]), 64'(2));
    check("roi1_second_valid", 64'(valid_a[1]), 64'(1));
    check("roi1_second_conf",  64'(conf_a[31:16]), 64'(120));

    // red/green tie, plus pixels on the exclusive end bounds
    pix(150, 100, 255, 0, 0, 150);
    pix(150, 100, 0, 255, 0, 150);
    pix(220, 100, 255, 0, 0, 7);
    pix(100, 180, 255, 0, 0, 7);
    fs_wait();
    check("tie_color", 64'(color_a[1:0]), 64'(1));
    check("tie_conf",  64'(conf_a[15:0]), 64'(150));

    // back-to-back frame_start -> overrun, single result
    frame_start = 1'b1; tick(); tick(); frame_start = 1'b0;
    nready = 0;
    repeat (8) begin tick(); if (ready_a) nready++; end
    check("overrun_pulses", 64'(nready), 64'(1));
    check("overrun_flag", 64'(ovr_a), 64'(1));
    pix(150, 100, 255, 0, 0, 10);
    fs_wait();
    check("after_overrun_conf", 64'(conf_a[15:0]), 64'(10));

    // out-of-range cfg index ignored; 8-bit instance saturates
    cfg(3, 0, 1000, 0, 1000);
    pix(150, 100, 255, 0, 0, 300);
    pix(10, 10, 255, 0, 0, 3);
    pix(400, 400, 255, 0, 0, 3);
    fs_wait();
    check("sat_conf_a", 64'(conf_a[15:0]), 64'(300));
    check("sat_conf_b", 64'(conf_b[7:0]), 64'(255));
    check("sat_valid_b", 64'(valid_b[0]), 64'(1));
    check("cfg3_roi1_conf", 64'(conf_a[31:16]), 64'(3));

    // randomized frames
    for (int f = 0; f < 14; f++) begin
      nb = $urandom_range(300, 600);
      for (int c = 0; c < nb; c++) begin
        pixel_valid = ($urandom_range(0, 3) != 0);
        x_coord = 10'($urandom_range(0, 320));
        y_coord = 10'($urandom_range(0, 240));
        sel = $urandom_range(0, 3);
        case (sel)
          0: begin pixel_r = 8'($urandom_range(180, 255)); pixel_g = 8'($urandom_range(0, 100)); pixel_b = 8'($urandom_range(0, 100)); end
          1: begin pixel_r = 8'($urandom_range(0, 100)); pixel_g = 8'($urandom_range(180, 255)); pixel_b = 8'($urandom_range(0, 100)); end
          2: begin pixel_r = 8'($urandom_range(0, 100)); pixel_g = 8'($urandom_range(0, 100)); pixel_b = 8'($urandom_range(180, 255)); end
          default: begin pixel_r = 8'($urandom); pixel_g = 8'($urandom); pixel_b = 8'($urandom); end
        endcase
        cfg_we = ($urandom_range(0, 49) == 0);
        cfg_idx = 2'($urandom_range(0, 3));
        cfg_xs = 10'($urandom_range(0, 200)); cfg_xe = 10'($urandom_range(0, 330));
        cfg_ys = 10'($urandom_range(0, 150)); cfg_ye = 10'($urandom_range(0, 250));
        tick();
      end
      pixel_valid = 1'b0;
      cfg_we = 1'b0;
      sel = $urandom_range(0, 3);
      frame_start = 1'b1; tick(); frame_start = 1'b0;
      if (sel == 1) begin
        gap = $urandom_range(1, 3);
        repeat (gap - 1) tick();
        frame_start = 1'b1; tick(); frame_start = 1'b0;
      end else if (sel == 2) begin
        // abort the decision in flight
        tick();
        rst_n = 1'b0; tick(); tick();
        rst_n = 1'b1;
      end
      repeat (5) tick();
    end

    repeat (6) tick();
    check("queue_drained", 64'(qa.size() + qb.size()), 64'(0));
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/multi_roi_color_detector.md
MULTI_ROI_COLOR_DETECTOR -- requirements
Module: multi_roi_color_detector

Interface
REQ-001 Parameters: NUM_ROI, default 2, number of independent ROIs (legal range 1..4).
REQ-002 Parameters: CNT_W, default 16, width of per-colour pixel counters and confidence.
REQ-003 Parameters: MIN_CONFIDENCE, default 100, minimum winning count for a valid result.
REQ-004 Parameters: RED_R_MIN/RED_G_MAX/RED_B_MAX, GREEN_R_MAX/GREEN_G_MIN/GREEN_B_MAX, BLUE_R_MAX/BLUE_G_MAX/BLUE_B_MIN, 8-bit, defaults 180/100/100, 100/180/100, 100/100/180.
REQ-005 Parameters: DEF_X_START, DEF_X_END, DEF_Y_START, DEF_Y_END, 10-bit, defaults 100, 220, 60, 180, the reset bounds of ROI 0.
REQ-006 Ports: clk  in  1  single clock, all logic on rising edge.
REQ-007 Ports: reset  in  1  asynchronous, active-low; 0 = reset.
REQ-008 Ports: pixel_valid in 1; frame_start in 1 (one-cycle pulse); x_coord in 10; y_coord in 10; pixel_r/pixel_g/pixel_b in 8 each.
REQ-009 Ports: cfg_we in 1; cfg_idx in 2; cfg_x_start, cfg_x_end, cfg_y_start, cfg_y_end in 10 each.
REQ-010 Ports: roi_color out 2*NUM_ROI; roi_valid out NUM_ROI; roi_confidence out CNT_W*NUM_ROI; result_ready out 1; overrun out 1; busy out 1.

Function
REQ-011 Colour code SHALL be 00 none, 01 red, 10 green, 11 blue; ROI i occupies bits [2i+1:2i].
REQ-012 Pixel SHALL be in ROI i when pixel_valid, x_start<=x<x_end, y_start<=y<y_end, using active bounds; start>=end disables the ROI.
REQ-013 Classification SHALL use the REQ-004 thresholds (MIN as >=, MAX as <=); if several match, priority red>green>blue.
REQ-014 Each ROI SHALL keep three CNT_W counters incremented by one per matching in-ROI pixel; counters saturate at all-ones.
REQ-015 cfg_we with cfg_idx<NUM_ROI SHALL write that ROI's shadow bounds; cfg_idx>=NUM_ROI SHALL be ignored.
REQ-016 Active bounds SHALL load from shadow only on frame_start; later writes in a frame never affect that frame.
REQ-017 FSM states: IDLE, ACCUM, DECIDE. IDLE->ACCUM on first frame_start (no decision made).
REQ-018 ACCUM->DECIDE on frame_start: snapshot all counters to hold registers, clear counters, same cycle.
REQ-019 Pixel valid in the frame_start cycle SHALL be counted into the new frame using the newly loaded bounds.
REQ-020 DECIDE SHALL process one ROI per cycle, index 0 to NUM_ROI-1, then return to ACCUM; busy=1 in DECIDE only.
REQ-021 Per ROI: winner = largest count, ties red>green>blue; if winner count<MIN_CONFIDENCE then colour 00, valid 0, else winner code, valid 1; confidence = winner count.
REQ-022 roi_color/roi_valid/roi_confidence SHALL update together in the cycle after the last ROI is decided and hold until the next update.
REQ-023 result_ready SHALL pulse high one cycle, coincident with REQ-022 update: NUM_ROI+1 cycles after frame_start.
REQ-024 frame_start during DECIDE SHALL clear counters and reload bounds, SHALL NOT restart or re-snapshot the decision, and SHALL set sticky overrun.
REQ-025 overrun SHALL clear only on reset.

Reset
REQ-026 On reset=0: FSM IDLE; counters, hold registers, outputs all 0; result_ready 0; overrun 0; busy 0.
REQ-027 On reset: ROI 0 active and shadow bounds = DEF_* values; ROIs 1..NUM_ROI-1 bounds all 0 (disabled).
REQ-028 Reset asserted mid-DECIDE SHALL abort with no result_ready pulse; release resumes in IDLE.

Verification
REQ-029 Reset, frame_start, 200 pixels (255,0,0) at (150,100), frame_start -> 3 cycles later result_ready=1, roi_color[1:0]=01, roi_valid[0]=1, roi_confidence[15:0]=200.
REQ-030 50 blue pixels in ROI 0 then frame_start -> roi_color[1:0]=00, roi_valid[0]=0, confidence=50.
REQ-031 Program ROI 1 x 0..50, y 0..50 mid-frame; pixels (10,10) green ×120 in that frame and ×120 next frame -> first decision ROI1 colour 00 conf 0; second decision 10, conf 120.
REQ-032 Equal 150 red and 150 green pixels in ROI 0 -> colour 01 (tie priority); pixel (220,100) and (100,180) not counted.
REQ-033 Second frame_start one cycle after first -> overrun=1, exactly one result_ready pulse, next frame counters start from 0.
REQ-034 Force counter to 16'hFFFE, feed 5 matching pixels -> count holds 16'hFFFF; cfg_idx=3 write with NUM_ROI=2 changes no bounds.
